rank_cmd_arbiter: RTL and testbench

RANK_CMD_ARBITER -- requirements
Module: rank_cmd_arbiter

---
 rtl/rank_cmd_arbiter_pkg.sv | 14 +
 rtl/rank_turnaround_timer.sv | 38 +++
 rtl/rank_cmd_arbiter.sv | 127 ++++++++++++
 tb/tb_rank_cmd_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/rank_cmd_arbiter_pkg.sv
// Shared definitions for the rank command-bus arbiter.
// Holds the default geometry and timing constants and the arbiter state enum.
package rank_cmd_arbiter_pkg;

    localparam int DEF_NUM_RANK   = 4;
    localparam int DEF_TRTRS      = 2;
    localparam int DEF_MAX_STREAK = 8;

    typedef enum logic {
        ARB  = 1'b0,
        TURN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rank_turnaround_timer.sv
// Rank-to-rank turnaround window timer.
// The window opens in the detection cycle. The timer then covers the remaining
// tRTRS-1 cycles that the arbiter spends in TURN.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : detection-cycle pulse that starts a window
//   active   : window cycles remain after the detection cycle
//   last     : this is the final TURN cycle; the arbiter returns to ARB next
module rank_turnaround_timer
    import rank_cmd_arbiter_pkg::*;
#(
    parameter int tRTRS = DEF_TRTRS
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active,
    output logic last
);

    localparam int CW = $clog2(tRTRS + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(tRTRS - 1);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign active = (count != '0);
    assign last   = (count == CW'(1));

endmodule

// File: rtl/rank_cmd_arbiter.sv
// Command-bus arbiter for ranks sharing one channel.
// Arbitration is sticky round-robin. The last rank keeps the bus until its
// streak reaches MAX_STREAK while another rank waits. Switching to a different
// rank costs a tRTRS-cycle bus turnaround, and no grant is issued during it.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   rankReq           : per-rank request level
//   cmdStall          : channel-wide grant inhibit
//   rankGrant         : one-hot grant, combinational from state and requests
//   grantValid        : any grant this cycle
//   grantRank         : granted rank index, 0 when no grant
//   rankTransition    : pulse in the cycle a turnaround is detected
//   cmdTurnaroundFree : low while a turnaround window is in progress
module rank_cmd_arbiter
    import rank_cmd_arbiter_pkg::*;
#(
    parameter int NUM_RANK   = DEF_NUM_RANK,
    parameter int tRTRS      = DEF_TRTRS,
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RANK-1:0]         rankReq,
    input  logic                        cmdStall,
    output logic [NUM_RANK-1:0]         rankGrant,
    output logic                        grantValid,
    output logic [$clog2(NUM_RANK)-1:0] grantRank,
    output logic                        rankTransition,
    output logic                        cmdTurnaroundFree
);

    localparam int RW = $clog2(NUM_RANK);
    localparam int SW = $clog2(MAX_STREAK + 1);

    arb_state_t    state_q, state_d;
    logic [RW-1:0] last_rank, pending_rank, winner, grant_idx;
    logic          last_valid;
    logic [SW-1:0] streak;
    logic          found, keep, other_req, arb_ok, grant_fire, transition;
    logic          timer_active, timer_last;

    // Round-robin search starting just after the last rank.
    // After reset (no last rank yet) the search starts at rank 0.
    always_comb begin
        int start;
        int idx;
        found  = 1'b0;
        winner = '0;
        start  = last_valid ? (int'(last_rank) + 1) : 0;
        for (int i = 0; i < NUM_RANK; i++) begin
            idx = (start + i) % NUM_RANK;
            if (!found && rankReq[idx]) begin
                found  = 1'b1;
                winner = RW'(idx);
            end
        end
    end

    assign other_req = |(rankReq & ~(NUM_RANK'(1) << last_rank));
    assign keep      = last_valid && rankReq[last_rank] &&
                       ((streak < SW'(MAX_STREAK)) || !other_req);
    assign arb_ok    = (state_q == ARB) && !cmdStall && !rst;

    // A winner is only issued directly when there is no prior rank. If the
    // last rank cannot keep the bus, the winner always differs from it, so
    // switching costs a turnaround.
    assign grant_fire = arb_ok && (keep || (!last_valid && found));
    assign transition = arb_ok && last_valid && !keep && found;
    assign grant_idx  = keep ? last_rank : winner;

    assign rankGrant         = grant_fire ? (NUM_RANK'(1) << grant_idx) : '0;
    assign grantValid        = grant_fire;
    assign grantRank         = grant_fire ? grant_idx : '0;
    assign rankTransition    = transition;
    assign cmdTurnaroundFree = rst || !(transition || timer_active);

    rank_turnaround_timer #(.tRTRS(tRTRS)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (transition),
        .active (timer_active),
        .last   (timer_last)
    );

    // A one-cycle turnaround needs no TURN state. In that case the window is
    // only the detection cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (transition && (tRTRS > 1)) state_d = TURN;
            TURN:    if (timer_last) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            last_rank    <= '0;
            last_valid   <= 1'b0;
            streak       <= '0;
            pending_rank <= '0;
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                last_rank  <= grant_idx;
                last_valid <= 1'b1;
                if (!keep)
                    streak <= SW'(1);
                else if (streak != SW'(MAX_STREAK))
                    streak <= streak + SW'(1);
            end
            if (transition) begin
                pending_rank <= winner;
                if (tRTRS == 1) begin
                    last_rank <= winner;
                    streak    <= '0;
                end
            end
            if (state_q == TURN && timer_last) begin
                last_rank <= pending_rank;
                streak    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rank_cmd_arbiter.sv
module tb_rank_cmd_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rankReq = 4'b0000;
    logic       cmdStall = 1'b0;
    logic [3:0] rankGrant;
    logic       grantValid;
    logic [1:0] grantRank;
    logic       rankTransition;
    logic       cmdTurnaroundFree;

    int checks = 0;
    int failures = 0;

    rank_cmd_arbiter #(.NUM_RANK(4), .tRTRS(2), .MAX_STREAK(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .rankReq           (rankReq),
        .cmdStall          (cmdStall),
        .rankGrant         (rankGrant),
        .grantValid        (grantValid),
        .grantRank         (grantRank),
        .rankTransition    (rankTransition),
        .cmdTurnaroundFree (cmdTurnaroundFree)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] req;
        logic       stall;
        logic [3:0] g;
        logic       t;
        logic       f;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] req, input logic stall,
                                input logic [3:0] g, input logic t, input logic f);
        vec_t v;
        v.r = r; v.req = req; v.stall = stall; v.g = g; v.t = t; v.f = f;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset, then a single rank held: granted every cycle, never a transition
        add(1, 4'b0001, 0, 4'b0000, 0, 1);
        add(1, 4'b0000, 0, 4'b0000, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 4'b0001, 0, 1);
        // rank0 -> rank2: D pulse, D+1 gap, D+2 grant
        add(0, 4'b0100, 0, 4'b0000, 1, 0);
        add(0, 4'b0100, 0, 4'b0000, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 0, 1);
        // move to rank3, then 0011 wraps to rank0
        add(0, 4'b1000, 0, 4'b0000, 1, 0);
        add(0, 4'b1000, 0, 4'b0000, 0, 0);
        add(0, 4'b1000, 0, 4'b1000, 0, 1);
        add(0, 4'b0011, 0, 4'b0000, 1, 0);
        add(0, 4'b0011, 0, 4'b0000, 0, 0);
        // streak limit: 8 rank0, gap, 8 rank1, gap, rank0
        for (int i = 0; i < 8; i++) add(0, 4'b0011, 0, 4'b0001, 0, 1);
        add(0, 4'b0011, 0, 4'b0000, 1, 0);
        add(0, 4'b0011, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 4'b0011, 0, 4'b0010, 0, 1);
        add(0, 4'b0011, 0, 4'b0000, 1, 0);
        add(0, 4'b0011, 0, 4'b0000, 0, 0);
        add(0, 4'b0011, 0, 4'b0001, 0, 1);
        // stall on D+1 does not stretch the window
        add(0, 4'b0010, 0, 4'b0000, 1, 0);
        add(0, 4'b0010, 1, 4'b0000, 0, 0);
        add(0, 4'b0010, 0, 4'b0010, 0, 1);
        // stall in ARB blocks grant and transition
        add(0, 4'b0010, 1, 4'b0000, 0, 1);
        add(0, 4'b0010, 0, 4'b0010, 0, 1);
        add(0, 4'b0100, 1, 4'b0000, 0, 1);
        add(0, 4'b0100, 0, 4'b0000, 1, 0);
        // pending rank2 drops during TURN: rank0 needs a new turnaround
        add(0, 4'b0001, 0, 4'b0000, 0, 0);
        add(0, 4'b0001, 0, 4'b0000, 1, 0);
        add(0, 4'b0001, 0, 4'b0000, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 0, 1);
        // idle keeps last rank: no turnaround to resume rank0
        add(0, 4'b0000, 0, 4'b0000, 0, 1);
        add(0, 4'b0001, 0, 4'b0001, 0, 1);
        // reset at D+1 aborts the window
        add(0, 4'b0010, 0, 4'b0000, 1, 0);
        add(1, 4'b0010, 0, 4'b0000, 0, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 1);
        add(0, 4'b0100, 0, 4'b0100, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [1:0] exp_rank;
            exp_rank = 2'd0;
            for (int b = 0; b < 4; b++) if (vecs[i].g[b]) exp_rank = 2'(b);
            @(negedge clk);
            rst      = vecs[i].r;
            rankReq  = vecs[i].req;
            cmdStall = vecs[i].stall;
            #1;
            check("rankGrant", i, rankGrant, vecs[i].g);
            check("grantValid", i, {3'b0, grantValid}, {3'b0, |vecs[i].g});
            check("grantRank", i, {2'b0, grantRank}, {2'b0, exp_rank});
            check("rankTransition", i, {3'b0, rankTransition}, {3'b0, vecs[i].t});
            check("cmdTurnaroundFree", i, {3'b0, cmdTurnaroundFree}, {3'b0, vecs[i].f});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
